// File: rtl/fpga_cfg_loader_if.sv
// rtl/fpga_cfg_loader_if.sv - host word streams (load in, readback out) for the config loader
interface fpga_cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - bit-serial config chain programmer and non-destructive readback engine
module fpga_cfg_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESETB,
    fpga_cfg_loader_if.slave host,
    input  logic             start,
    input  logic             rb_mode,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             cfg_shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CHAIN_END  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_WAIT  = 3'd1,
        LD_SHIFT = 3'd2,
        RB_SHIFT = 3'd3,
        RB_HOLD  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] rb_data;
    logic [IDX_W-1:0]  bit_idx;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              last_chain_bit;
    logic              last_word_bit;
    logic              chain_full;

    assign last_chain_bit = (bit_cnt == CHAIN_LAST);
    assign chain_full     = (bit_cnt == CHAIN_END);
    // The final word of a chain that is not a word multiple ends early.
    assign last_word_bit  = (bit_idx == LAST_IDX) || last_chain_bit;
    assign accept         = host.in_valid && in_ready;

    assign host.in_ready  = in_ready;
    assign host.out_valid = out_valid;
    assign host.out_data  = rb_data;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = rb_mode ? RB_SHIFT : LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (host.in_valid) begin
                    state_nx = LD_SHIFT;
                end
            end
            LD_SHIFT: begin
                if (last_chain_bit) begin
                    state_nx = FINISH;
                end else if (last_word_bit && !host.in_valid) begin
                    state_nx = LD_WAIT;
                end
            end
            RB_SHIFT: begin
                if (last_word_bit) begin
                    state_nx = RB_HOLD;
                end
            end
            RB_HOLD: begin
                if (host.out_ready) begin
                    state_nx = chain_full ? FINISH : RB_SHIFT;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cfg_shift = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            LD_WAIT: in_ready = 1'b1;
            LD_SHIFT: begin
                cfg_shift = 1'b1;
                ccff_head = sreg[0];
                // Overlapping the next accept with the last shift keeps the stream bubble-free.
                in_ready  = last_word_bit && !last_chain_bit;
            end
            RB_SHIFT: begin
                cfg_shift = 1'b1;
                ccff_head = ccff_tail;
            end
            RB_HOLD: out_valid = 1'b1;
            FINISH:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sreg    <= '0;
            rb_data <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                bit_cnt <= '0;
                bit_idx <= '0;
            end else if (cfg_shift && !chain_full) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (accept) begin
                sreg    <= host.in_data;
                bit_idx <= '0;
            end else if (state == LD_SHIFT) begin
                sreg    <= sreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end else if (state == RB_SHIFT) begin
                bit_idx <= last_word_bit ? '0 : bit_idx + 1'b1;
            end

            // Clearing on the first bit of each word zero-pads a short final word.
            if (state == RB_SHIFT) begin
                if (bit_idx == '0) begin
                    rb_data <= WORD_W'(ccff_tail);
                end else begin
                    rb_data[bit_idx] <= ccff_tail;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader with a 20-flop chain model
module tb_fpga_cfg_loader;
    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;
    localparam int CNT_W     = 16;
    localparam logic [CHAIN_LEN-1:0] IMAGE = 20'hF3CA5;

    logic             CLK = 1'b0;
    logic             RESETB = 1'b0;
    logic             start = 1'b0;
    logic             rb_mode = 1'b0;
    logic             ccff_head;
    logic             ccff_tail;
    logic             cfg_shift;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;
    logic [CHAIN_LEN-1:0] chain;
    logic             chain_clr = 1'b0;

    fpga_cfg_loader_if #(.WORD_W(WORD_W)) bus ();

    fpga_cfg_loader #(
        .WORD_W(WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RESETB(RESETB),
        .host(bus),
        .start(start),
        .rb_mode(rb_mode),
        .ccff_head(ccff_head),
        .ccff_tail(ccff_tail),
        .cfg_shift(cfg_shift),
        .busy(busy),
        .done(done),
        .bit_cnt(bit_cnt)
    );

    always #5 CLK = ~CLK;

    assign ccff_tail = chain[0];
    always @(posedge CLK) begin
        if (chain_clr) chain <= '0;
        else if (cfg_shift) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rb_phase = 1'b0;
    int ld_shifts, rb_shifts, done_cnt, first_shift, last_shift;
    logic [CNT_W-1:0] done_bitcnt;
    bit exp_head[$];
    logic [WORD_W-1:0] exp_word[$];
    logic [WORD_W-1:0] held;
    bit holding = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (RESETB) begin
            if (cfg_shift && !rb_phase) begin
                ld_shifts++;
                if (first_shift < 0) first_shift = cyc;
                last_shift = cyc;
                if (exp_head.size() == 0) chk("unexpected_shift", 1, 0);
                else chk("ccff_head", 32'(ccff_head), 32'(exp_head.pop_front()));
            end
            if (cfg_shift && rb_phase) rb_shifts++;
            if (bus.out_valid) begin
                chk("shift_during_hold", 32'(cfg_shift), 0);
                if (holding) chk("out_data_stable", 32'(bus.out_data), 32'(held));
                held = bus.out_data;
                holding = 1'b1;
                if (bus.out_ready) begin
                    if (exp_word.size() == 0) chk("unexpected_word", 1, 0);
                    else chk("out_data", 32'(bus.out_data), 32'(exp_word.pop_front()));
                    holding = 1'b0;
                end
            end
            if (done) begin
                done_cnt++;
                done_bitcnt = bit_cnt;
            end
        end
    end

    task automatic clear_stats();
        ld_shifts = 0;
        rb_shifts = 0;
        done_cnt = 0;
        first_shift = -1;
        last_shift = -1;
        holding = 1'b0;
    endtask

    task automatic push_image(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        logic [23:0] img;
        img = {w2, w1, w0};
        for (int i = 0; i < CHAIN_LEN; i++) exp_head.push_back(img[i]);
    endtask

    task automatic clear_chain();
        chain_clr = 1'b1;
        @(posedge CLK); #1;
        chain_clr = 1'b0;
    endtask

    task automatic start_cmd(input logic mode);
        start = 1'b1;
        rb_mode = mode;
        @(posedge CLK); #1;
        start = 1'b0;
        rb_mode = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        bus.in_data = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("in_ready_timeout", 0, 1);
        @(posedge CLK); #1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_data"},  32'(bus.out_data), 0);
        chk({tag, "_ccff_head"}, 32'(ccff_head), 0);
        chk({tag, "_cfg_shift"}, 32'(cfg_shift), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_bit_cnt"},   32'(bit_cnt), 0);
    endtask

    task automatic stream_load();
        start_cmd(1'b0);
        send_word(8'hA5);
        send_word(8'h3C);
        send_word(8'h0F);
        bus.in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        clear_stats();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        RESETB = 1'b1;
        clear_chain();

        // Streamed load, with a stray start mid-load and a 4th word after the chain is full.
        clear_stats();
        rb_phase = 1'b0;
        push_image(8'hA5, 8'h3C, 8'h0F);
        start_cmd(1'b0);
        chk("busy_after_start", 32'(busy), 1);
        chk("in_ready_after_start", 32'(bus.in_ready), 1);
        send_word(8'hA5);
        bus.in_data = 8'h3C;
        start = 1'b1;
        rb_mode = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        rb_mode = 1'b0;
        send_word(8'h3C);
        send_word(8'h0F);
        bus.in_data = 8'h77;
        wait_done();
        chk("load_in_ready_extra", 32'(bus.in_ready), 0);
        chk("load_busy_after", 32'(busy), 0);
        chk("load_shift_cnt", 32'(ld_shifts), 20);
        chk("load_shift_span", 32'(last_shift - first_shift + 1), 20);
        chk("load_done_cnt", 32'(done_cnt), 1);
        chk("load_bit_cnt", 32'(done_bitcnt), 20);
        chk("load_image", 32'(chain), 32'(IMAGE));
        chk("load_head_left", 32'(exp_head.size()), 0);
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;

        // Host gap of 5 idle cycles between words.
        clear_chain();
        clear_stats();
        push_image(8'hA5, 8'h3C, 8'h0F);
        start_cmd(1'b0);
        send_word(8'hA5);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("gap_no_shift", 32'(cfg_shift), 0);
        end
        @(posedge CLK); #1;
        send_word(8'h3C);
        send_word(8'h0F);
        bus.in_valid = 1'b0;
        wait_done();
        chk("gap_shift_cnt", 32'(ld_shifts), 20);
        chk("gap_done_cnt", 32'(done_cnt), 1);
        chk("gap_image", 32'(chain), 32'(IMAGE));
        chk("gap_head_left", 32'(exp_head.size()), 0);

        // Readback with 7 cycles of backpressure on the second word.
        clear_stats();
        rb_phase = 1'b1;
        exp_word.push_back(8'hA5);
        exp_word.push_back(8'h3C);
        exp_word.push_back(8'h0F);
        bus.out_ready = 1'b1;
        start_cmd(1'b1);
        wait_out_valid();
        @(posedge CLK); #1;
        bus.out_ready = 1'b0;
        wait_out_valid();
        repeat (7) @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
        wait_done();
        chk("rb_shift_cnt", 32'(rb_shifts), 20);
        chk("rb_words_left", 32'(exp_word.size()), 0);
        chk("rb_done_cnt", 32'(done_cnt), 1);
        chk("rb_bit_cnt", 32'(done_bitcnt), 20);
        chk("rb_image_kept", 32'(chain), 32'(IMAGE));
        chk("rb_busy_after", 32'(busy), 0);
        rb_phase = 1'b0;

        // Asynchronous reset after 9 loaded bits, then a clean reload.
        clear_chain();
        clear_stats();
        exp_head.delete();
        push_image(8'hA5, 8'h3C, 8'h0F);
        start_cmd(1'b0);
        send_word(8'hA5);
        bus.in_data = 8'h3C;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK); #1;
            if (ld_shifts >= 9) break;
        end
        chk("abort_reached_9", 32'(ld_shifts >= 9), 1);
        @(posedge CLK); #2;
        RESETB = 1'b0;
        #1;
        check_all_zero("abort");
        exp_head.delete();
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        RESETB = 1'b1;
        clear_chain();
        clear_stats();
        push_image(8'hA5, 8'h3C, 8'h0F);
        stream_load();
        chk("reload_shift_cnt", 32'(ld_shifts), 20);
        chk("reload_done_cnt", 32'(done_cnt), 1);
        chk("reload_image", 32'(chain), 32'(IMAGE));
        chk("reload_bit_cnt", 32'(bit_cnt), 20);
        chk("reload_head_left", 32'(exp_head.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Bitstream programmer and readback engine for the fabric configuration chain, the serial chain of reset-able config flip-flops entered at `ccff_head` and exited at `ccff_tail`. On the write side it accepts configuration words from a host over a valid/ready interface and shifts them bit-serially into the chain. On the read side it circulates the chain once, `ccff_tail` back to `ccff_head`, and packs the bits it sees into words on a second valid/ready interface. The block sits between the host/JTAG bridge and the top-level chain, in the same clock domain as the chain flops.

## Interface
Parameters:
- `WORD_W`, default 8: host word width in bits.
- `CHAIN_LEN`, default 1024: number of flops in the configuration chain.
- `CNT_W`, default 16: width of the bit counter. Must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `CLK`  in  1: clock. The chain flops shift on this same clock.
- `RESETB`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle command pulse. Ignored while `busy`=1.
- `rb_mode`  in  1: sampled together with `start`. 0 = load, 1 = readback.
- `in_data`  in  WORD_W: configuration word, shifted LSB first.
- `in_valid`  in  1: host word valid.
- `in_ready`  out  1: loader can accept a word.
- `out_data`  out  WORD_W: readback word. The first bit captured is the LSB.
- `out_valid`  out  1: readback word valid.
- `out_ready`  in  1: host accepts the readback word.
- `ccff_head`  out  1: serial data into the chain.
- `ccff_tail`  in  1: serial data out of the chain.
- `cfg_shift`  out  1: chain shift enable. The chain advances one bit on each `CLK` edge where this is 1.
- `busy`  out  1: a command is in progress.
- `done`  out  1: one-cycle pulse when a command completes.
- `bit_cnt`  out  CNT_W: number of chain bits shifted so far in the current command.

## Operation
- States:
  - IDLE
  - LD_WAIT: no word held.
  - LD_SHIFT: a word is shifting.
  - RB_SHIFT
  - RB_HOLD: a readback word is waiting for the host.
  - FINISH
- Reset: state IDLE. All outputs are 0: `in_ready`, `out_valid`, `out_data`, `ccff_head`, `cfg_shift`, `busy`, `done`, `bit_cnt`.
- IDLE transitions:
  - `start`=1 with `rb_mode`=0 → LD_WAIT.
  - `start`=1 with `rb_mode`=1 → RB_SHIFT.
  - In both cases `busy`=1 from the next cycle and `bit_cnt` is cleared to 0.
- `in_ready` definition: `in_ready`=1 in LD_WAIT, and in LD_SHIFT on the cycle that shifts the last bit of the current word, provided `bit_cnt`+1 < CHAIN_LEN.
- Load path:
  - A word is accepted on `in_valid`&`in_ready`, and `in_data` is latched into the shift register.
  - LD_SHIFT drives `cfg_shift`=1 and `ccff_head`=sreg[0] on every cycle. The register shifts right and `bit_cnt` increments.
  - Partial final word: when CHAIN_LEN is not a multiple of WORD_W, the last word shifts only CHAIN_LEN mod WORD_W bits. Its upper bits are discarded.
  - At the end of a word with no new word accepted → LD_WAIT. `cfg_shift`=0 and the chain holds.
  - When `bit_cnt` reaches CHAIN_LEN → FINISH. Any `in_valid` asserted afterwards is not accepted.
- Readback path:
  - RB_SHIFT drives `cfg_shift`=1 and `ccff_head`=`ccff_tail`, so chain contents are preserved after a full lap.
  - The `ccff_tail` value of each shift cycle is captured into the output packer.
  - After WORD_W bits, or the final chain bit (zero-padded) → RB_HOLD with `out_valid`=1 and `cfg_shift`=0.
  - On `out_valid`&`out_ready`: go back to RB_SHIFT, or to FINISH if `bit_cnt`=CHAIN_LEN.
  - `out_data` is stable while `out_valid`=1.
- FINISH: `done`=1 for one cycle, then IDLE, where `busy` drops.
- `start` while busy: ignored, with no effect on the current command.
- `RESETB` asserted mid-command: immediate return to IDLE. The partial word is dropped and the chain contents are undefined. The host must restart.

## Timing
- Load start:
  - `start` on cycle 0 → `in_ready`=1 on cycle 1.
  - Word accepted on cycle k → first `cfg_shift`=1 on cycle k+1.
- Load throughput: with `in_valid` held high, words stream with zero bubbles, one chain bit per cycle. A full load takes CHAIN_LEN shift cycles plus 1 accept cycle.
- Load completion: `done` is asserted on the cycle after the last shift.
- Readback stalls: RB_HOLD inserts one stall cycle per word, plus one for each cycle `out_ready` is low. `cfg_shift` never asserts while `out_valid`=1.
- Counter width: `bit_cnt` saturates at CHAIN_LEN and never wraps.

## Test plan
- Load with CHAIN_LEN=20, WORD_W=8: words 0xA5, 0x3C, 0x0F with `in_valid` held high.
  - Exactly 20 `cfg_shift` cycles with no bubbles.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - `done` pulses once; `bit_cnt`=20.
- Host gap: idle 5 cycles between words → `cfg_shift`=0 for those cycles; the final chain image is identical to the previous test.
- Readback after load: the chain model returns the loaded image.
  - `out_data` = 0xA5, 0x3C, 0x0F, with the last word zero-padded to 0x0F.
  - Chain contents are unchanged afterwards.
- Backpressure: `out_ready` held low for 7 cycles on the second word → `out_data` is stable, `cfg_shift`=0 throughout, no bit is lost.
- Busy/extra input:
  - `start` pulsed mid-load → ignored.
  - A 4th `in_valid` after 20 bits → `in_ready`=0 and the word is not consumed.
- Reset mid-load: `RESETB` low after 9 bits → all outputs 0 asynchronously. A new load then completes normally.
